// File: rtl/systolic_matmul_engine.sv
// Purpose : output-stationary ROWS x COLS systolic matmul, C = A(ROWS x K) * B(K x COLS), K set per job.
// Latency : Done rises ROWS+COLS enabled cycles after the edge that accepts the final beat (next cycle if K=0).
// Backpr. : In_Ready high only in LOAD with EN high; bubbles (In_Valid=0) ride the array as invalid slots.
//
// Ports:
//   CLK, ASYNC_RST (async, active low), SYNC_RST (sync, active high), EN (global freeze when low)
//   Start, Signed_Mode, K_Len   - job control, sampled in IDLE/DONE
//   In_Valid/In_Ready, A_Col, B_Row - one unskewed beat: column k of A, row k of B
//   Busy, Done, Result          - status and per-PE accumulators
module systolic_matmul_engine #(
    parameter int WIDTH     = 8,
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int MAX_K     = 16,
    parameter int ACC_WIDTH = 2*WIDTH + $clog2(MAX_K),
    localparam int KW       = $clog2(MAX_K + 1)
) (
    input  logic                 CLK,
    input  logic                 ASYNC_RST,
    input  logic                 SYNC_RST,
    input  logic                 EN,
    input  logic                 Start,
    input  logic                 Signed_Mode,
    input  logic [KW-1:0]        K_Len,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [WIDTH-1:0]     A_Col  [0:ROWS-1],
    input  logic [WIDTH-1:0]     B_Row  [0:COLS-1],
    output logic                 Busy,
    output logic                 Done,
    output logic [ACC_WIDTH-1:0] Result [0:ROWS-1][0:COLS-1]
);

    localparam int DW         = $clog2(ROWS + COLS);
    localparam int DRAIN_LAST = ROWS + COLS - 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t          state;
    logic            done_q;
    logic            sgn_lat;
    logic [KW-1:0]   k_lat;
    logic [KW-1:0]   beat_cnt;
    logic [DW-1:0]   drain_cnt;
    logic [KW-1:0]   k_clamp;
    logic            accept;
    logic            start_acc;

    assign k_clamp   = (K_Len > KW'(MAX_K)) ? KW'(MAX_K) : K_Len;
    assign In_Ready  = EN && (state == LOAD);
    assign accept    = In_Valid && In_Ready;
    // A Start that is actually taken; clears accumulators and in-flight slots on the same edge.
    assign start_acc = EN && !SYNC_RST && Start && ((state == IDLE) || (state == DONE));
    assign Busy      = (state == LOAD) || (state == DRAIN);
    assign Done      = done_q;

    // ---------------------------------------------------------------- control FSM
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            sgn_lat   <= 1'b0;
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else if (SYNC_RST) begin
            // Clear wins over EN so a frozen engine can still be flushed.
            state     <= IDLE;
            done_q    <= 1'b0;
            sgn_lat   <= 1'b0;
            k_lat     <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
        end else if (EN) begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        sgn_lat  <= Signed_Mode;
                        k_lat    <= k_clamp;
                        beat_cnt <= '0;
                        if (k_clamp == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (In_Valid) begin
                        if (beat_cnt == k_lat - KW'(1)) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + KW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // Last PE accumulates ROWS+COLS-2 edges after the final accept;
                    // Done lands two edges later so Result is settled when it rises.
                    if (drain_cnt == DW'(DRAIN_LAST)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- input skew
    // Row r of A is delayed r edges and column c of B c edges, so the k-th
    // operands meet at PE(r,c) on edge accept+r+c. Stage 0 uses the live inputs.
    logic [WIDTH-1:0] a_sk_dat [0:ROWS-1];
    logic             a_sk_vld [0:ROWS-1];
    logic [WIDTH-1:0] b_sk_dat [0:COLS-1];
    logic             b_sk_vld [0:COLS-1];

    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_sk_dat[r] = A_Col[r];
            assign a_sk_vld[r] = accept;
        end else begin : g_sr
            logic [WIDTH-1:0] sr_dat [0:r-1];
            logic [r-1:0]     sr_vld;
            always_ff @(posedge CLK or negedge ASYNC_RST) begin
                if (!ASYNC_RST) begin
                    for (int i = 0; i < r; i++) sr_dat[i] <= '0;
                    sr_vld <= '0;
                end else if (SYNC_RST || start_acc) begin
                    sr_vld <= '0;
                end else if (EN) begin
                    sr_dat[0] <= A_Col[r];
                    sr_vld[0] <= accept;
                    for (int i = 1; i < r; i++) begin
                        sr_dat[i] <= sr_dat[i-1];
                        sr_vld[i] <= sr_vld[i-1];
                    end
                end
            end
            assign a_sk_dat[r] = sr_dat[r-1];
            assign a_sk_vld[r] = sr_vld[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_sk_dat[c] = B_Row[c];
            assign b_sk_vld[c] = accept;
        end else begin : g_sr
            logic [WIDTH-1:0] sr_dat [0:c-1];
            logic [c-1:0]     sr_vld;
            always_ff @(posedge CLK or negedge ASYNC_RST) begin
                if (!ASYNC_RST) begin
                    for (int i = 0; i < c; i++) sr_dat[i] <= '0;
                    sr_vld <= '0;
                end else if (SYNC_RST || start_acc) begin
                    sr_vld <= '0;
                end else if (EN) begin
                    sr_dat[0] <= B_Row[c];
                    sr_vld[0] <= accept;
                    for (int i = 1; i < c; i++) begin
                        sr_dat[i] <= sr_dat[i-1];
                        sr_vld[i] <= sr_vld[i-1];
                    end
                end
            end
            assign b_sk_dat[c] = sr_dat[c-1];
            assign b_sk_vld[c] = sr_vld[c-1];
        end
    end

    // ---------------------------------------------------------------- PE array
    logic [WIDTH-1:0] a_out_dat [0:ROWS-1][0:COLS-1];
    logic             a_out_vld [0:ROWS-1][0:COLS-1];
    logic [WIDTH-1:0] b_out_dat [0:ROWS-1][0:COLS-1];
    logic             b_out_vld [0:ROWS-1][0:COLS-1];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [WIDTH-1:0]     a_in, b_in;
            logic                 a_in_vld, b_in_vld;
            logic [WIDTH-1:0]     a_q, b_q;
            logic                 a_q_vld, b_q_vld;
            logic [ACC_WIDTH-1:0] acc_q;
            logic [2*WIDTH-1:0]   a_x, b_x, prod;
            logic [ACC_WIDTH-1:0] prod_ext;

            if (c == 0) begin : g_a_edge
                assign a_in     = a_sk_dat[r];
                assign a_in_vld = a_sk_vld[r];
            end else begin : g_a_link
                assign a_in     = a_out_dat[r][c-1];
                assign a_in_vld = a_out_vld[r][c-1];
            end
            if (r == 0) begin : g_b_edge
                assign b_in     = b_sk_dat[c];
                assign b_in_vld = b_sk_vld[c];
            end else begin : g_b_link
                assign b_in     = b_out_dat[r-1][c];
                assign b_in_vld = b_out_vld[r-1][c];
            end

            // Extending both operands to 2*WIDTH first makes one multiplier give
            // the exact signed or unsigned product modulo 2^(2*WIDTH).
            assign a_x      = {{WIDTH{sgn_lat & a_in[WIDTH-1]}}, a_in};
            assign b_x      = {{WIDTH{sgn_lat & b_in[WIDTH-1]}}, b_in};
            assign prod     = a_x * b_x;
            assign prod_ext = {{(ACC_WIDTH-2*WIDTH){sgn_lat & prod[2*WIDTH-1]}}, prod};

            always_ff @(posedge CLK or negedge ASYNC_RST) begin
                if (!ASYNC_RST) begin
                    a_q <= '0; a_q_vld <= 1'b0;
                    b_q <= '0; b_q_vld <= 1'b0;
                    acc_q <= '0;
                end else if (SYNC_RST || start_acc) begin
                    a_q_vld <= 1'b0;
                    b_q_vld <= 1'b0;
                    acc_q   <= '0;
                end else if (EN) begin
                    a_q     <= a_in;
                    a_q_vld <= a_in_vld;
                    b_q     <= b_in;
                    b_q_vld <= b_in_vld;
                    if (a_in_vld && b_in_vld) acc_q <= acc_q + prod_ext;
                end
            end

            assign a_out_dat[r][c] = a_q;
            assign a_out_vld[r][c] = a_q_vld;
            assign b_out_dat[r][c] = b_q;
            assign b_out_vld[r][c] = b_q_vld;
            assign Result[r][c]    = acc_q;
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Purpose : scoreboard bench driving a 4x4 and a 3x3 engine with the same beats.
// Latency : expected Done latency pushed per job (ROWS+COLS after last accept, plus stalls).
// Backpr. : driver holds each beat until In_Ready; bubbles and EN stalls are injected.
module tb_systolic_matmul_engine;

    logic       CLK = 1'b0;
    logic       ASYNC_RST, SYNC_RST, EN, Start, Signed_Mode, In_Valid;
    logic [4:0] K_Len;
    logic [7:0] a_col [0:3];
    logic [7:0] b_row [0:3];
    logic [7:0] a_col3 [0:2];
    logic [7:0] b_row3 [0:2];

    logic        in_ready4, busy4, done4;
    logic        in_ready3, busy3, done3;
    logic [19:0] res4 [0:3][0:3];
    logic [19:0] res3 [0:2][0:2];
    logic [319:0] flat4;
    logic [179:0] flat3;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    assign a_col3[0] = a_col[0];
    assign a_col3[1] = a_col[1];
    assign a_col3[2] = a_col[2];
    assign b_row3[0] = b_row[0];
    assign b_row3[1] = b_row[1];
    assign b_row3[2] = b_row[2];

    systolic_matmul_engine u_dut4 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
        .Start(Start), .Signed_Mode(Signed_Mode), .K_Len(K_Len),
        .In_Valid(In_Valid), .In_Ready(in_ready4), .A_Col(a_col), .B_Row(b_row),
        .Busy(busy4), .Done(done4), .Result(res4)
    );

    systolic_matmul_engine #(.ROWS(3), .COLS(3)) u_dut3 (
        .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .EN(EN),
        .Start(Start), .Signed_Mode(Signed_Mode), .K_Len(K_Len),
        .In_Valid(In_Valid), .In_Ready(in_ready3), .A_Col(a_col3), .B_Row(b_row3),
        .Busy(busy3), .Done(done3), .Result(res3)
    );

    always_comb begin
        flat4 = '0;
        flat3 = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) flat4[(r*4+c)*20 +: 20] = res4[r][c];
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) flat3[(r*3+c)*20 +: 20] = res3[r][c];
    end

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------ reference model
    logic [7:0] am [0:3][0:15];
    logic [7:0] bm [0:15][0:3];

    function automatic logic [319:0] model(input int k, input bit sgn, input int nr, input int nc);
        logic [319:0] f;
        logic [19:0]  s;
        logic signed [31:0] av, bv, p;
        f = '0;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                s = '0;
                for (int i = 0; i < k; i++) begin
                    if (sgn) begin
                        av = $signed(am[r][i]);
                        bv = $signed(bm[i][c]);
                    end else begin
                        av = {24'b0, am[r][i]};
                        bv = {24'b0, bm[i][c]};
                    end
                    p = av * bv;
                    s = s + p[19:0];
                end
                f[(r*nc+c)*20 +: 20] = s;
            end
        end
        return f;
    endfunction

    task automatic set_3x3();
        logic [7:0] a9 [0:8];
        logic [7:0] b9 [0:8];
        a9 = '{8'd4, 8'd3, 8'd7, 8'd4, 8'd4, 8'd7, 8'd6, 8'd8, 8'd2};
        b9 = '{8'd9, 8'd4, 8'd5, 8'd10, 8'd4, 8'd5, 8'd7, 8'd4, 8'd7};
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 16; i++) begin
                am[r][i] = '0;
                bm[i][r] = '0;
            end
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 3; i++) begin
                am[r][i] = a9[r*3+i];
                bm[r][i] = b9[r*3+i];
            end
    endtask

    task automatic set_fill(input logic [7:0] av, input logic [7:0] bv, input bit rnd);
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 16; i++) begin
                am[r][i] = rnd ? 8'($urandom) : av;
                bm[i][r] = rnd ? 8'($urandom) : bv;
            end
    endtask

    // ------------------------------------------------------------ scoreboard / monitor
    logic [319:0] exp4_q[$];
    logic [319:0] exp3_q[$];
    int lat4_q[$];
    int lat3_q[$];
    int cyc = 0;
    int ref4 = 0, ref3 = 0;
    logic d4_prev = 1'b0, d3_prev = 1'b0;
    bit seen_rdy = 1'b0;

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (ASYNC_RST) begin
            if (in_ready4 || in_ready3) seen_rdy = 1'b1;
            if (EN && Start && !busy4) ref4 = cyc + 1;
            if (EN && Start && !busy3) ref3 = cyc + 1;
            if (In_Valid && in_ready4) ref4 = cyc + 1;
            if (In_Valid && in_ready3) ref3 = cyc + 1;
            if (done4 && !d4_prev) begin
                if (exp4_q.size() == 0) chk("spurious_done4", 320'd1, 320'd0);
                else begin
                    chk("res4", flat4, exp4_q.pop_front());
                    chk("lat4", 320'(cyc - ref4), 320'(lat4_q.pop_front()));
                end
            end
            if (done3 && !d3_prev) begin
                if (exp3_q.size() == 0) chk("spurious_done3", 320'd1, 320'd0);
                else begin
                    chk("res3", 320'(flat3), exp3_q.pop_front());
                    chk("lat3", 320'(cyc - ref3), 320'(lat3_q.pop_front()));
                end
            end
        end
        d4_prev = done4;
        d3_prev = done3;
    end

    // ------------------------------------------------------------ driver
    task automatic drive_beat(input int i);
        int t;
        for (int r = 0; r < 4; r++) a_col[r] = am[r][i];
        for (int c = 0; c < 4; c++) b_row[c] = bm[i][c];
        In_Valid = 1'b1;
        t = 0;
        while (!(in_ready4 && in_ready3) && t < 20) begin
            @(posedge CLK); #1;
            t++;
        end
        if (t >= 20) chk("rdy_timeout", 320'd0, 320'd1);
        @(posedge CLK); #1;
        In_Valid = 1'b0;
    endtask

    task automatic run_job(input int k, input bit sgn, input int gap_len, input int stall);
        int kb, t;
        kb = (k > 16) ? 16 : k;
        exp4_q.push_back(model(kb, sgn, 4, 4));
        exp3_q.push_back(model(kb, sgn, 3, 3));
        lat4_q.push_back(kb == 0 ? 0 : 8 + stall);
        lat3_q.push_back(kb == 0 ? 0 : 6 + stall);
        seen_rdy = 1'b0;
        @(posedge CLK); #1;
        Start = 1'b1; Signed_Mode = sgn; K_Len = 5'(k);
        @(posedge CLK); #1;
        Start = 1'b0;
        for (int i = 0; i < kb; i++) begin
            drive_beat(i);
            if (i == 0 && gap_len > 0) begin
                repeat (gap_len) @(posedge CLK);
                #1;
            end
        end
        if (stall > 0) begin
            @(posedge CLK); #1;
            EN = 1'b0;
            repeat (stall) @(posedge CLK);
            #1;
            EN = 1'b1;
        end
        t = 0;
        while ((exp4_q.size() != 0 || exp3_q.size() != 0) && t < 100) begin
            @(posedge CLK);
            t++;
        end
        if (t >= 100) begin
            chk("done_timeout", 320'd0, 320'd1);
            exp4_q.delete(); exp3_q.delete(); lat4_q.delete(); lat3_q.delete();
        end
        if (kb == 0) chk("k0_no_ready", 320'(seen_rdy), 320'd0);
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        ASYNC_RST = 1'b0; SYNC_RST = 1'b0; EN = 1'b1; Start = 1'b0;
        Signed_Mode = 1'b0; K_Len = '0; In_Valid = 1'b0;
        for (int i = 0; i < 4; i++) begin a_col[i] = '0; b_row[i] = '0; end
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_res4", flat4, '0);
        chk("reset_res3", 320'(flat3), '0);
        chk("reset_busy", 320'({busy4, busy3}), '0);
        chk("reset_done", 320'({done4, done3}), '0);
        chk("reset_rdy", 320'({in_ready4, in_ready3}), '0);
        @(posedge CLK); #1;
        ASYNC_RST = 1'b1;

        set_3x3();
        run_job(3, 1'b0, 0, 0);          // back-to-back beats
        run_job(3, 1'b0, 2, 0);          // 2-cycle bubble between beats 1 and 2
        set_fill(8'hFF, 8'h02, 1'b0);
        run_job(4, 1'b1, 0, 0);          // -1*2*4 = -8
        run_job(4, 1'b0, 0, 0);          // 255*2*4 = 2040
        run_job(0, 1'b0, 0, 0);          // empty job
        set_3x3();
        run_job(3, 1'b0, 0, 3);          // EN stall in DRAIN

        // Abort a job mid-LOAD with the async reset.
        set_fill(8'h00, 8'h00, 1'b1);
        @(posedge CLK); #1;
        Start = 1'b1; Signed_Mode = 1'b0; K_Len = 5'd5;
        @(posedge CLK); #1;
        Start = 1'b0;
        drive_beat(0);
        drive_beat(1);
        ASYNC_RST = 1'b0;
        @(negedge CLK);
        chk("abort_res4", flat4, '0);
        chk("abort_res3", 320'(flat3), '0);
        chk("abort_busy", 320'({busy4, busy3}), '0);
        chk("abort_done", 320'({done4, done3}), '0);
        chk("abort_rdy", 320'({in_ready4, in_ready3}), '0);
        @(posedge CLK); #1;
        ASYNC_RST = 1'b1;

        set_fill(8'h00, 8'h00, 1'b1);
        run_job(16, 1'b1, 0, 0);         // fresh full-length signed job
        set_fill(8'h00, 8'h00, 1'b1);
        run_job(20, 1'b0, 0, 0);         // K_Len above MAX_K clamps to 16

        repeat (5) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_matmul_engine.md
Name: systolic_matmul_engine

Overview:
- Output-stationary ROWS x COLS systolic matrix-multiply engine computing C = A(ROWS x K) * B(K x COLS), with K selectable at run time up to MAX_K.
- Accepts one unskewed beat per cycle: column k of A and row k of B. Diagonal skew, drain timing and completion signalling are generated internally, so upstream buffers need no knowledge of array geometry.
- Adds signed/unsigned mode, valid/ready streaming with bubbles, and a Start/Done handshake. Sits between the operand buffers and the accumulator/activation stage.

Parameters:
- WIDTH, 8, operand width in bits.
- ROWS, 4, PE rows (rows of A and C).
- COLS, 4, PE columns (columns of B and C).
- MAX_K, 16, largest supported inner dimension.
- ACC_WIDTH, 2*WIDTH+$clog2(MAX_K), accumulator and result width.
- KW (localparam), $clog2(MAX_K+1), width of K_Len.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- ASYNC_RST  in  1  asynchronous, active-low reset.
- SYNC_RST  in  1  synchronous, active-high clear; same end state as ASYNC_RST.
- EN  in  1  global enable; low freezes all state.
- Start  in  1  begin a new job; sampled in IDLE or DONE only.
- Signed_Mode  in  1  1 = two's-complement operands; latched at Start.
- K_Len  in  KW  inner dimension, 0..MAX_K; latched at Start. Values above MAX_K are clamped to MAX_K.
- In_Valid  in  1  A_Col/B_Row carry a beat.
- In_Ready  out  1  engine accepts a beat this cycle.
- A_Col  in  [0:ROWS-1] x WIDTH  column k of A.
- B_Row  in  [0:COLS-1] x WIDTH  row k of B.
- Busy  out  1  high in LOAD and DRAIN.
- Done  out  1  one-cycle completion pulse.
- Result  out  [0:ROWS-1][0:COLS-1] x ACC_WIDTH  accumulator of PE(r,c).

Behaviour:
- Reset values (async or sync): state IDLE; In_Ready, Busy and Done = 0; all Result entries = 0; skew pipelines and valid bits cleared. A reset mid-job aborts the job with no Done.
- EN = 0: no state, counter, pipeline or accumulator changes. In_Ready = 0. Done holds its current value.
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE/DONE + Start:
  - Clear all accumulators and latch Signed_Mode and K_Len.
  - If K_Len = 0, go to DONE and pulse Done next cycle; Result is all zeros.
  - Otherwise go to LOAD.
- LOAD: In_Ready = 1. A beat is accepted on an edge where In_Valid && In_Ready. After the K_Len-th accepted beat, go to DRAIN. Cycles with In_Valid = 0 are bubbles and are not counted.
- DRAIN: In_Ready = 0 while a counter runs. Go to DONE so that Done is high exactly ROWS+COLS enabled cycles after the edge that accepted the final beat.
- DONE: Done = 1 for exactly one enabled cycle. Result then holds stable until the next accepted Start.
- Start is ignored in LOAD and DRAIN.
- Skew: A_Col[r] is delayed by r stages and B_Row[c] by c stages. A moves right and B moves down one PE per cycle. Each datum carries a valid bit, so bubbles travel as invalid slots.
- PE accumulate rule: PE(r,c) adds a*b only when both incoming valid bits are set; invalid slots never alter the sum.
- Arithmetic: the product is 2*WIDTH bits, sign- or zero-extended to ACC_WIDTH per the latched mode. Accumulation wraps modulo 2^ACC_WIDTH, with no saturation.
- Simultaneous Start and Done cycle in DONE: the new job starts and accumulators clear on that edge.

Test Plan:
- 3x3 unsigned (ROWS=COLS=3, K=3), with A = {4,3,7; 4,4,7; 6,8,2} and B = {9,4,5; 10,4,5; 7,4,7}, beats back-to-back:
  - Result rows must be {115,56,84}, {125,60,89} and {148,64,84}.
  - Done must assert 6 cycles after the last beat is accepted.
- Same job with In_Valid deasserted for 2 cycles between beats 1 and 2 -> identical Result; Done is 2 cycles later than the back-to-back case.
- Default parameters (4x4, WIDTH 8, ACC_WIDTH 20), K=4, all A = 0xFF, all B = 0x02:
  - Signed_Mode = 1 -> every Result = 0xFFFF8 (-8).
  - Signed_Mode = 0 -> every Result = 0x007F8 (2040).
- K_Len = 0 -> Done pulses the cycle after Start; all Result = 0; In_Ready never asserts.
- EN held low for 3 cycles during DRAIN -> Done is delayed by exactly 3 cycles; Result is unchanged versus the run without the stall.
- ASYNC_RST asserted mid-LOAD, then a Start is issued with a fresh job:
  - During reset, Result = 0, Busy = 0 and Done = 0.
  - The fresh job completes with correct results, unaffected by the aborted job.
